// File: rtl/sdr_protocol_checker.sv
// ---------------------------------------------------------------------------
// sdr_protocol_checker
//
// Passive observer of an SDR SDRAM command bus.
// - Decodes each sampled command.
// - Tracks the open/closed state of every bank.
// - Checks tRCD, tRP and tRAS per bank, plus the basic open/close rules.
// - Reconstructs the read-data window from the CL and BL values latched by MRS.
// It never blocks a command: a violating command still updates the state.
//
// Ports
//   clk, rst                    : clock, asynchronous active-high reset
//   cke, cs_n, ras_n, cas_n,
//   we_n, addr, ba              : SDRAM command/address pins (sampled on clk rise)
//   cmd_valid, cmd_code         : registered decoded command (0 = NOP)
//   bank_open                   : per-bank row-open flags
//   err_valid, err_code,
//   err_bank                    : one-cycle violation report
//   err_count                   : saturating violation counter
//   rd_valid                    : high while the device drives read data
// ---------------------------------------------------------------------------
module sdr_protocol_checker #(
   parameter int ADDR_WIDTH = 13,
   parameter int BA_WIDTH   = 2,
   parameter int T_RCD      = 2,
   parameter int T_RP       = 2,
   parameter int T_RAS      = 5
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cke,
   input  logic                       cs_n,
   input  logic                       ras_n,
   input  logic                       cas_n,
   input  logic                       we_n,
   input  logic [ADDR_WIDTH-1:0]      addr,
   input  logic [BA_WIDTH-1:0]        ba,
   output logic                       cmd_valid,
   output logic [2:0]                 cmd_code,
   output logic [(2**BA_WIDTH)-1:0]   bank_open,
   output logic                       err_valid,
   output logic [2:0]                 err_code,
   output logic [BA_WIDTH-1:0]        err_bank,
   output logic [15:0]                err_count,
   output logic                       rd_valid
);

   localparam int NUM_BANKS = 2**BA_WIDTH;
   localparam int CNT_W     = 8;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] RCD_C   = CNT_W'(T_RCD);
   localparam logic [CNT_W-1:0] RP_C    = CNT_W'(T_RP);
   localparam logic [CNT_W-1:0] RAS_C   = CNT_W'(T_RAS);

   localparam logic [2:0] C_NOP = 3'd0, C_ACT = 3'd1, C_RD  = 3'd2, C_WR = 3'd3,
                          C_PRE = 3'd4, C_REF = 3'd5, C_MRS = 3'd6, C_BST = 3'd7;

   // Elapsed-edge counters, saturating so an idle bank never looks "too recent".
   logic [CNT_W-1:0] r_act_cnt [NUM_BANKS];
   logic [CNT_W-1:0] r_pre_cnt [NUM_BANKS];

   logic [1:0]  r_cl;
   logic [3:0]  r_bl;
   // Slot k holds an event that takes effect on rd_valid k+1 edges from now.
   logic [2:0]  r_slot_rd;
   logic [2:0]  r_slot_bst;
   logic [3:0]  r_slot_bl [3];
   logic [3:0]  r_rem;

   logic [2:0]          w_cmd;
   logic                w_err;
   logic [2:0]          w_err_code;
   logic [BA_WIDTH-1:0] w_err_bank;
   logic [BA_WIDTH-1:0] w_low_open;
   logic [BA_WIDTH-1:0] w_low_ras;
   logic                w_ras_any;
   logic                w_unused_addr;

   assign w_unused_addr = ^addr;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

   always_comb begin
      w_cmd = C_NOP;
      if (cke && !cs_n) begin
         case ({ras_n, cas_n, we_n})
            3'b011:  w_cmd = C_ACT;
            3'b101:  w_cmd = C_RD;
            3'b100:  w_cmd = C_WR;
            3'b010:  w_cmd = C_PRE;
            3'b001:  w_cmd = C_REF;
            3'b000:  w_cmd = C_MRS;
            3'b110:  w_cmd = C_BST;
            default: w_cmd = C_NOP;
         endcase
      end
   end

   // Scan downwards so the lowest matching bank index is the one kept.
   always_comb begin
      w_low_open = '0;
      w_low_ras  = '0;
      w_ras_any  = 1'b0;
      for (int i = NUM_BANKS-1; i >= 0; i--) begin
         if (bank_open[i]) w_low_open = BA_WIDTH'(i);
         if (bank_open[i] && (r_act_cnt[i] < RAS_C)) begin
            w_low_ras = BA_WIDTH'(i);
            w_ras_any = 1'b1;
         end
      end
   end

   // Each command class can only raise its own errors.
   // The if/else order below is therefore the priority order.
   always_comb begin
      w_err      = 1'b0;
      w_err_code = 3'd0;
      w_err_bank = ba;
      case (w_cmd)
         C_ACT: begin
            if (bank_open[ba]) begin
               w_err = 1'b1; w_err_code = 3'd1;
            end else if (r_pre_cnt[ba] < RP_C) begin
               w_err = 1'b1; w_err_code = 3'd4;
            end
         end
         C_RD, C_WR: begin
            if (!bank_open[ba]) begin
               w_err = 1'b1; w_err_code = 3'd2;
            end else if (r_act_cnt[ba] < RCD_C) begin
               w_err = 1'b1; w_err_code = 3'd3;
            end
         end
         C_PRE: begin
            if (addr[10]) begin
               if (w_ras_any) begin
                  w_err = 1'b1; w_err_code = 3'd5; w_err_bank = w_low_ras;
               end
            end else if (bank_open[ba] && (r_act_cnt[ba] < RAS_C)) begin
               w_err = 1'b1; w_err_code = 3'd5;
            end
         end
         C_REF, C_MRS: begin
            if (|bank_open) begin
               w_err = 1'b1; w_err_code = 3'd6; w_err_bank = w_low_open;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmd_valid  <= 1'b0;
         cmd_code   <= 3'd0;
         bank_open  <= '0;
         err_valid  <= 1'b0;
         err_code   <= 3'd0;
         err_bank   <= '0;
         err_count  <= 16'd0;
         rd_valid   <= 1'b0;
         r_cl       <= 2'd3;
         r_bl       <= 4'd1;
         r_slot_rd  <= 3'b000;
         r_slot_bst <= 3'b000;
         r_rem      <= 4'd0;
         for (int i = 0; i < 3; i++) r_slot_bl[i] <= 4'd0;
         for (int i = 0; i < NUM_BANKS; i++) begin
            r_act_cnt[i] <= CNT_MAX;
            r_pre_cnt[i] <= CNT_MAX;
         end
      end else begin
         cmd_valid <= (w_cmd != C_NOP);
         cmd_code  <= w_cmd;
         err_valid <= w_err;
         err_code  <= w_err_code;
         err_bank  <= w_err ? w_err_bank : '0;
         if (w_err && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;

         for (int i = 0; i < NUM_BANKS; i++) begin
            r_act_cnt[i] <= sat_inc(r_act_cnt[i]);
            r_pre_cnt[i] <= sat_inc(r_pre_cnt[i]);
         end

         // Counters restart at 1 so a command m edges later sees exactly m.
         if (w_cmd == C_ACT) begin
            bank_open[ba] <= 1'b1;
            r_act_cnt[ba] <= CNT_W'(1);
         end
         if (w_cmd == C_PRE) begin
            if (addr[10]) begin
               bank_open <= '0;
               for (int i = 0; i < NUM_BANKS; i++) r_pre_cnt[i] <= CNT_W'(1);
            end else begin
               bank_open[ba] <= 1'b0;
               r_pre_cnt[ba] <= CNT_W'(1);
            end
         end
         if (w_cmd == C_MRS) begin
            if ((addr[6:4] == 3'd2) || (addr[6:4] == 3'd3)) r_cl <= addr[5:4];
            case (addr[2:0])
               3'd0:    r_bl <= 4'd1;
               3'd1:    r_bl <= 4'd2;
               3'd2:    r_bl <= 4'd4;
               3'd3:    r_bl <= 4'd8;
               default: ;
            endcase
         end

         // Read-latency delay line: a READ/BST at edge n lands in slot CL-1
         // and reaches slot 0 so that it acts at edge n+CL.
         r_slot_rd    <= {1'b0, r_slot_rd[2:1]};
         r_slot_bst   <= {1'b0, r_slot_bst[2:1]};
         r_slot_bl[0] <= r_slot_bl[1];
         r_slot_bl[1] <= r_slot_bl[2];
         r_slot_bl[2] <= 4'd0;
         if (w_cmd == C_RD) begin
            r_slot_rd[r_cl - 2'd1]  <= 1'b1;
            r_slot_bst[r_cl - 2'd1] <= 1'b0;
            r_slot_bl[r_cl - 2'd1]  <= r_bl;
         end else if (w_cmd == C_BST) begin
            r_slot_rd[r_cl - 2'd1]  <= 1'b0;
            r_slot_bst[r_cl - 2'd1] <= 1'b1;
         end

         // A new burst start overrides any remaining beats (truncation).
         if (r_slot_rd[0]) begin
            rd_valid <= 1'b1;
            r_rem    <= r_slot_bl[0] - 4'd1;
         end else if (r_slot_bst[0]) begin
            rd_valid <= 1'b0;
            r_rem    <= 4'd0;
         end else if (r_rem != 4'd0) begin
            rd_valid <= 1'b1;
            r_rem    <= r_rem - 4'd1;
         end else begin
            rd_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sdr_protocol_checker.sv
// ---------------------------------------------------------------------------
// tb_sdr_protocol_checker
//
// Directed bench for sdr_protocol_checker with hand-computed expectations.
// Uses T_RCD=2, T_RP=2, T_RAS=5 and four banks.
// The variable cyc numbers the sampling edges of each scenario from 0.
// rd_hist[k] holds rd_valid as registered at edge k.
// ---------------------------------------------------------------------------
module tb_sdr_protocol_checker;

   localparam logic [2:0] P_ACT = 3'b011, P_RD  = 3'b101, P_PRE = 3'b010,
                          P_REF = 3'b001, P_MRS = 3'b000, P_BST = 3'b110,
                          P_NOP = 3'b111;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cke = 1'b1;
   logic        cs_n = 1'b1;
   logic        ras_n = 1'b1;
   logic        cas_n = 1'b1;
   logic        we_n = 1'b1;
   logic [12:0] addr = '0;
   logic [1:0]  ba = '0;
   logic        cmd_valid;
   logic [2:0]  cmd_code;
   logic [3:0]  bank_open;
   logic        err_valid;
   logic [2:0]  err_code;
   logic [1:0]  err_bank;
   logic [15:0] err_count;
   logic        rd_valid;

   int          n_chk = 0;
   int          n_err = 0;
   int          cyc = 0;
   logic [63:0] rd_hist = '0;
   logic [63:0] rd_exp = '0;

   sdr_protocol_checker #(
      .ADDR_WIDTH(13), .BA_WIDTH(2), .T_RCD(2), .T_RP(2), .T_RAS(5)
   ) dut (
      .clk(clk), .rst(rst), .cke(cke), .cs_n(cs_n), .ras_n(ras_n),
      .cas_n(cas_n), .we_n(we_n), .addr(addr), .ba(ba),
      .cmd_valid(cmd_valid), .cmd_code(cmd_code), .bank_open(bank_open),
      .err_valid(err_valid), .err_code(err_code), .err_bank(err_bank),
      .err_count(err_count), .rd_valid(rd_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step(input logic k, input logic c, input logic [2:0] rcw,
                       input logic [1:0] b, input logic [12:0] a);
      cke = k; cs_n = c; {ras_n, cas_n, we_n} = rcw; ba = b; addr = a;
      @(posedge clk); #1;
      if (cyc < 64) rd_hist[cyc] = rd_valid;
      cyc++;
   endtask

   task automatic cmd(input logic [2:0] rcw, input logic [1:0] b, input logic [12:0] a);
      step(1'b1, 1'b0, rcw, b, a);
   endtask

   task automatic nop(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b1, P_NOP, 2'd0, 13'd0);
   endtask

   task automatic do_reset();
      cke = 1'b1; cs_n = 1'b1; {ras_n, cas_n, we_n} = P_NOP; ba = '0; addr = '0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      cyc = 0;
      rd_hist = '0;
   endtask

   function automatic logic [63:0] all_outs();
      return 64'({cmd_valid, cmd_code, bank_open, err_valid, err_code,
                  err_bank, err_count, rd_valid});
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      @(posedge clk); #1;
      check("reset_outs", all_outs(), 64'd0);
      do_reset();

      // tRCD: ACT b1 @0, READ b1 @1 violates, READ @2 clean
      cmd(P_ACT, 2'd1, 13'd0);
      check("act_cmd", {cmd_valid, cmd_code}, {1'b1, 3'd1});
      check("act_open", bank_open, 4'b0010);
      check("act_noerr", err_valid, 1'b0);
      cmd(P_RD, 2'd1, 13'd0);
      check("rcd_err", {err_valid, err_code, err_bank}, {1'b1, 3'd3, 2'd1});
      check("rcd_cnt", err_count, 16'd1);
      cmd(P_RD, 2'd1, 13'd0);
      check("rcd_clean", {err_valid, cmd_code}, {1'b0, 3'd2});
      check("rcd_clean_cnt", err_count, 16'd1);

      // tRAS then tRP on bank 2
      do_reset();
      cmd(P_ACT, 2'd2, 13'd0);
      nop(2);
      cmd(P_PRE, 2'd2, 13'd0);
      check("ras_err", {err_valid, err_code, err_bank}, {1'b1, 3'd5, 2'd2});
      check("ras_closed", bank_open, 4'b0000);
      cmd(P_ACT, 2'd2, 13'd0);
      check("rp_err", {err_valid, err_code, err_bank}, {1'b1, 3'd4, 2'd2});
      check("rp_cnt", err_count, 16'd2);
      check("rp_still_opens", bank_open, 4'b0100);

      // Same, but the ACT waits until edge 5
      do_reset();
      cmd(P_ACT, 2'd2, 13'd0);
      nop(2);
      cmd(P_PRE, 2'd2, 13'd0);
      nop(1);
      cmd(P_ACT, 2'd2, 13'd0);
      check("rp_ok", {err_valid, err_count}, {1'b0, 16'd1});
      check("rp_ok_open", bank_open, 4'b0100);

      // REF with banks open; PRE-all then REF clean; PRE-all tRAS lowest bank
      do_reset();
      cmd(P_ACT, 2'd0, 13'd0);
      cmd(P_ACT, 2'd3, 13'd0);
      check("two_open", {err_valid, bank_open}, {1'b0, 4'b1001});
      cmd(P_REF, 2'd0, 13'd0);
      check("ref_err", {err_valid, err_code, err_bank}, {1'b1, 3'd6, 2'd0});
      nop(4);
      cmd(P_PRE, 2'd0, 13'h400);
      check("preall_ok", {err_valid, bank_open}, {1'b0, 4'b0000});
      cmd(P_REF, 2'd0, 13'd0);
      check("ref_ok", {cmd_valid, cmd_code, err_valid, bank_open}, {1'b1, 3'd5, 1'b0, 4'b0000});
      cmd(P_ACT, 2'd3, 13'd0);
      cmd(P_ACT, 2'd1, 13'd0);
      check("reopen", {err_valid, bank_open}, {1'b0, 4'b1010});
      cmd(P_PRE, 2'd2, 13'h400);
      check("preall_ras", {err_valid, err_code, err_bank}, {1'b1, 3'd5, 2'd1});

      // Read window: CL=3 BL=4 via MRS 0x032
      do_reset();
      cmd(P_MRS, 2'd0, 13'h032);
      check("mrs_cmd", {cmd_code, err_valid}, {3'd6, 1'b0});
      cmd(P_ACT, 2'd0, 13'd0);
      nop(8);
      cmd(P_RD, 2'd0, 13'd0);                 // edge 10
      nop(9);                                 // edges 11..19
      nop(10);                                // edges 20..29
      cmd(P_RD, 2'd0, 13'd0);                 // edge 30
      nop(1);
      cmd(P_RD, 2'd0, 13'd0);                 // edge 32
      nop(8);                                 // edges 33..40
      nop(9);                                 // edges 41..49
      cmd(P_RD, 2'd0, 13'd0);                 // edge 50
      cmd(P_BST, 2'd0, 13'd0);                // edge 51
      check("bst_cmd", {cmd_valid, cmd_code}, {1'b1, 3'd7});
      nop(8);                                 // edges 52..59
      rd_exp = '0;
      for (int k = 13; k <= 16; k++) rd_exp[k] = 1'b1;
      for (int k = 33; k <= 38; k++) rd_exp[k] = 1'b1;
      rd_exp[53] = 1'b1;
      check("rd_single", rd_hist[19:0], rd_exp[19:0]);
      check("rd_truncate", rd_hist[40:20], rd_exp[40:20]);
      check("rd_bst", rd_hist[59:41], rd_exp[59:41]);
      check("rd_no_err", err_count, 16'd0);

      // cke=0 / cs_n=1 commands are NOPs
      do_reset();
      cmd(P_RD, 2'd2, 13'd0);
      check("closed_rd", {err_valid, err_code, err_bank}, {1'b1, 3'd2, 2'd2});
      step(1'b0, 1'b0, P_RD, 2'd2, 13'd0);
      check("cke0_nop", {cmd_valid, cmd_code, err_valid}, {1'b0, 3'd0, 1'b0});
      step(1'b1, 1'b1, P_RD, 2'd2, 13'd0);
      check("csn1_nop", {cmd_valid, cmd_code, err_valid}, {1'b0, 3'd0, 1'b0});
      check("nop_cnt", err_count, 16'd1);

      // Reset in the middle of a burst, with three errors counted
      do_reset();
      cmd(P_MRS, 2'd0, 13'h033);              // CL=3, BL=8
      cmd(P_RD, 2'd0, 13'd0);
      cmd(P_RD, 2'd0, 13'd0);
      cmd(P_RD, 2'd0, 13'd0);
      nop(4);                                 // edges 4..7, burst active
      check("pre_rst_burst", {rd_valid, err_count}, {1'b1, 16'd3});
      #2 rst = 1'b1;
      #1 check("rst_async", all_outs(), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      cyc = 0;
      rd_hist = '0;
      nop(12);                                // edges 0..11
      check("rst_burst_gone", rd_hist[11:0], 64'd0);
      cmd(P_ACT, 2'd0, 13'd0);                // edge 12
      check("rst_act_ok", {err_valid, err_count, bank_open}, {1'b0, 16'd0, 4'b0001});
      nop(2);
      cmd(P_RD, 2'd0, 13'd0);                 // edge 15, CL=3 BL=1 again
      nop(5);                                 // edges 16..20
      rd_exp = '0;
      rd_exp[18] = 1'b1;
      check("rst_cl_bl", rd_hist[20:12], rd_exp[20:12]);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/sdr_protocol_checker.md
SDR_PROTOCOL_CHECKER -- requirements
Module: sdr_protocol_checker

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 13: SDRAM address width.
REQ-002 SHALL have parameter BA_WIDTH, default 2: bank-address width; NUM_BANKS = 2**BA_WIDTH.
REQ-003 SHALL have parameter T_RCD, default 2: minimum cycles from ACT to READ/WRITE on the same bank.
REQ-004 SHALL have parameter T_RP, default 2: minimum cycles from PRE to ACT on the same bank.
REQ-005 SHALL have parameter T_RAS, default 5: minimum cycles from ACT to PRE on the same bank.
REQ-006 SHALL have port clk, input, 1: sole clock; all inputs are sampled on its rising edge.
REQ-007 SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-008 SHALL have ports cke, cs_n, ras_n, cas_n, we_n, input, 1 each: SDRAM control pins.
REQ-009 SHALL have port addr, input, ADDR_WIDTH: SDRAM address.
REQ-010 SHALL have port ba, input, BA_WIDTH: bank address.
REQ-011 SHALL have ports cmd_valid (output, 1) and cmd_code (output, 3): decoded-command strobe and code.
REQ-012 SHALL have port bank_open, output, NUM_BANKS: per-bank row-open flags.
REQ-013 SHALL have ports err_valid (output, 1), err_code (output, 3) and err_bank (output, BA_WIDTH): violation report.
REQ-014 SHALL have port err_count, output, 16: saturating violation counter.
REQ-015 SHALL have port rd_valid, output, 1: asserted in cycles where the device drives read data.

Function
REQ-016 SHALL decode, only when cke=1 and cs_n=0, {ras_n,cas_n,we_n} as: 011 ACT (code 1), 101 READ (2), 100 WRITE (3), 010 PRE (4; addr[10]=1 means all banks), 001 REF (5), 000 MRS (6), 110 BST (7); 111 is NOP (code 0, cmd_valid=0).
REQ-017 SHALL treat cke=0 or cs_n=1 as NOP; timing counters still advance.
REQ-018 SHALL register cmd_valid/cmd_code, bank_open and error outputs one cycle after the sampling edge.
REQ-019 SHALL set bank_open[ba] on ACT and clear it on PRE (all banks if addr[10]=1); REF and MRS leave it unchanged.
REQ-020 SHALL keep per-bank saturating counters of elapsed edges since the last ACT and since the last PRE; a command at edge m after an event at edge n sees elapsed = m-n.
REQ-021 SHALL check, in priority order (lowest code wins): 1 ACT to open bank; 2 READ/WRITE to closed bank; 3 READ/WRITE with ACT elapsed < T_RCD; 4 ACT with PRE elapsed < T_RP; 5 PRE of an open bank with ACT elapsed < T_RAS; 6 REF or MRS with any bank open.
REQ-022 SHALL, for PRE-all and REF/MRS violations, report the lowest offending bank index in err_bank.
REQ-023 SHALL still apply the state update of a violating command (the checker observes, it never blocks).
REQ-024 SHALL pulse err_valid for exactly one cycle per violating command and increment err_count, saturating at 0xFFFF.
REQ-025 SHALL latch on MRS: CL = addr[6:4] (legal values 2,3; other values leave CL unchanged) and BL = 1,2,4,8 for addr[2:0] = 0,1,2,3 (others leave BL unchanged).
REQ-026 SHALL assert rd_valid for BL consecutive cycles, the first being the cycle registered at edge n+CL for a READ sampled at edge n.
REQ-027 SHALL, when a READ arrives while a burst is pending, truncate the earlier burst at the start of the new burst's data; no gaps or overlap.
REQ-028 SHALL ignore BST for read-burst purposes other than ending rd_valid at edge n+CL for a BST at edge n.

Reset
REQ-029 SHALL, on rst high, asynchronously clear cmd_valid, cmd_code, bank_open, err_valid, err_code, err_bank, err_count, rd_valid and pending bursts; set CL=3, BL=1; saturate all timing counters (no timing error right after reset).
REQ-030 SHALL, on reset asserted mid-burst, drop rd_valid in the same cycle and emit nothing further from that burst.

Verification (T_RCD=2, T_RP=2, T_RAS=5, BA_WIDTH=2)
REQ-031 SHALL cover: ACT b1 @0, READ b1 @1 -> err_valid, err_code=3, err_bank=1, err_count=1; READ @2 clean.
REQ-032 SHALL cover: ACT b2 @0, PRE b2 @3 -> err_code=5; ACT b2 @4 -> err_code=4; ACT b2 @5 clean.
REQ-033 SHALL cover: ACT b0, ACT b3, REF -> err_code=6, err_bank=0; PRE-all then REF -> no error, bank_open=0000.
REQ-034 SHALL cover: MRS addr=0x032 (CL=3, BL=4), READ @10 -> rd_valid high for edges 13..16 exactly; READ @12 -> rd_valid continuous 13..18.
REQ-035 SHALL cover: READ to closed bank plus cke=0 command -> err_code=2 only for the cke=1 case; the cke=0 command gives cmd_valid=0.
REQ-036 SHALL cover: rst pulse during an active burst with err_count=3 -> all outputs zero, CL=3/BL=1 restored, next ACT raises no error.
